// File: rtl/next_level_banner_ctrl.sv
// "Next Level" banner animator: slides a 152x112 bitmap in from above, holds it, slides it out, pulses done.
// Optional BANNER_SKIP_EN: skip during SLIDE_IN/HOLD jumps straight to SLIDE_OUT.
module next_level_banner_ctrl #(
   parameter int OBJECT_WIDTH  = 152,
   parameter int OBJECT_HEIGHT = 112,
   parameter int TARGET_X      = 244,
   parameter int TARGET_Y      = 184,
   parameter int SPEED_Y       = 8,
   parameter int HOLD_FRAMES   = 120,
   parameter int SCREEN_H      = 480
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        startOfFrame,
   input  logic [10:0] pixelX,
   input  logic [10:0] pixelY,
   input  logic        skip,
   output logic        InsideRectangle,
   output logic [10:0] offsetX,
   output logic [10:0] offsetY,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {IDLE, SLIDE_IN, HOLD, SLIDE_OUT, FINISH} state_t;

   localparam int HC_W = $clog2(HOLD_FRAMES);
   localparam logic signed [11:0] TOP_IDLE = 12'(-OBJECT_HEIGHT);
   localparam logic signed [11:0] TGT_Y    = 12'(TARGET_Y);
   localparam logic signed [11:0] SCR_H    = 12'(SCREEN_H);
   localparam logic signed [11:0] OBJ_H    = 12'(OBJECT_HEIGHT);
   localparam logic signed [11:0] STEP_Y   = 12'(SPEED_Y);
   localparam logic [10:0] X_LO = 11'(TARGET_X);
   localparam logic [10:0] X_HI = 11'(TARGET_X + OBJECT_WIDTH);
   localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_FRAMES - 1);

   state_t            state, state_n;
   logic signed [11:0] top_y, top_y_n, top_step;
   logic [HC_W-1:0]    hold_cnt, hold_cnt_n;
   logic               skip_go;

`ifdef BANNER_SKIP_EN
   assign skip_go = skip && (state == SLIDE_IN || state == HOLD);
`else
   logic unused_skip;
   assign unused_skip = skip;
   assign skip_go     = 1'b0;
`endif

   assign top_step = top_y + STEP_Y;

   always_comb begin
      state_n    = state;
      top_y_n    = top_y;
      hold_cnt_n = hold_cnt;
      case (state)
         IDLE: begin
            top_y_n = TOP_IDLE;
            if (start) state_n = SLIDE_IN;
         end
         SLIDE_IN: begin
            if (skip_go) begin
               state_n    = SLIDE_OUT;
               hold_cnt_n = '0;
            end else if (startOfFrame) begin
               if (top_step >= TGT_Y) begin
                  top_y_n    = TGT_Y;
                  hold_cnt_n = '0;
                  state_n    = HOLD;
               end else begin
                  top_y_n = top_step;
               end
            end
         end
         HOLD: begin
            if (skip_go) begin
               state_n    = SLIDE_OUT;
               hold_cnt_n = '0;
            end else if (startOfFrame) begin
               hold_cnt_n = hold_cnt + 1'b1;
               if (hold_cnt == HOLD_LAST) state_n = SLIDE_OUT;
            end
         end
         SLIDE_OUT: begin
            if (startOfFrame) begin
               top_y_n = top_step;
               if (top_step >= SCR_H) state_n = FINISH;
            end
         end
         FINISH: begin
            state_n = IDLE;
            top_y_n = TOP_IDLE;
         end
         default: begin
            state_n = IDLE;
            top_y_n = TOP_IDLE;
         end
      endcase
   end

   // Y test is signed so a banner partly above the screen still hits row 0.
   logic signed [11:0] py_s, dy;
   logic               in_x, in_y, hit;
   assign py_s = $signed({1'b0, pixelY});
   assign dy   = py_s - top_y;
   assign in_x = (pixelX >= X_LO) && (pixelX < X_HI);
   assign in_y = (py_s >= top_y) && (py_s < top_y + OBJ_H);
   assign hit  = (state != IDLE) && in_x && in_y;

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         top_y           <= TOP_IDLE;
         hold_cnt        <= '0;
         InsideRectangle <= 1'b0;
         offsetX         <= '0;
         offsetY         <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
      end else begin
         state           <= state_n;
         top_y           <= top_y_n;
         hold_cnt        <= hold_cnt_n;
         InsideRectangle <= hit;
         offsetX         <= hit ? (pixelX - X_LO) : 11'd0;
         offsetY         <= hit ? dy[10:0] : 11'd0;
         busy            <= (state_n != IDLE);
         done            <= (state_n == FINISH);
      end
   end

endmodule

// File: tb/tb_next_level_banner_ctrl.sv
// Self-checking bench for next_level_banner_ctrl: directed probe tables, multi-cycle sequences, random vs. frame-count model.
module tb_next_level_banner_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1, start = 1'b0, startOfFrame = 1'b0, skip = 1'b0;
   logic [10:0] pixelX = '0, pixelY = '0;
   logic        InsideRectangle, busy, done;
   logic [10:0] offsetX, offsetY;

   always #5 clk = ~clk;

   next_level_banner_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .startOfFrame(startOfFrame),
      .pixelX(pixelX), .pixelY(pixelY), .skip(skip),
      .InsideRectangle(InsideRectangle), .offsetX(offsetX), .offsetY(offsetY),
      .busy(busy), .done(done)
   );

`ifdef BANNER_SKIP_EN
   localparam bit SKIP_EN = 1'b1;
`else
   localparam bit SKIP_EN = 1'b0;
`endif
   localparam int N_IN   = (184 + 112 + 7) / 8;   // frames to reach the hold row
   localparam int N_HOLD = 120;

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         startOfFrame = 1'b1; tick();
         startOfFrame = 1'b0; tick();
      end
   endtask

   typedef struct { int px; int py; bit ei; int ex; int ey; } probe_t;
   probe_t tbl_a[4];
   probe_t tbl_b[5];

   task automatic probe(input string nm, input probe_t p);
      pixelX = 11'(p.px); pixelY = 11'(p.py);
      tick();
      chk({nm, "_in"}, int'(InsideRectangle), int'(p.ei));
      chk({nm, "_ox"}, int'(offsetX), p.ex);
      chk({nm, "_oy"}, int'(offsetY), p.ey);
   endtask

   // Reference model: animation described by frame counts and a slide-out base row.
   bit m_act, m_fin;
   int in_f, out_f, out_base;

   function automatic int m_top();
      int t;
      if (!m_act) return -112;
      if (out_f < 0) begin
         t = -112 + 8 * in_f;
         return (t > 184) ? 184 : t;
      end
      return out_base + 8 * out_f;
   endfunction

   task automatic m_step(input bit r, input bit st, input bit sof, input bit sk);
      if (r) begin
         m_act = 0; m_fin = 0;
      end else if (!m_act) begin
         if (st) begin m_act = 1; in_f = 0; out_f = -1; end
      end else if (m_fin) begin
         m_act = 0; m_fin = 0;
      end else if (SKIP_EN && sk && out_f < 0) begin
         out_base = m_top(); out_f = 0;
      end else if (sof) begin
         if (out_f < 0) begin
            in_f++;
            if (in_f == N_IN + N_HOLD) begin out_base = 184; out_f = 0; end
         end else begin
            out_f++;
            if (out_base + 8 * out_f >= 480) m_fin = 1;
         end
      end
   endtask

   initial begin
      int k, done_at, done_cnt, exp_k;
      bit busy_ok;
      bit r, st, sof, sk;
      int px, py, top, e_in, e_ox, e_oy;

      tbl_a[0] = '{300, 0, 1'b1, 56, 40};
      tbl_a[1] = '{300, 72, 1'b0, 0, 0};
      tbl_a[2] = '{300, 71, 1'b1, 56, 111};
      tbl_a[3] = '{243, 0, 1'b0, 0, 0};
      tbl_b[0] = '{244, 184, 1'b1, 0, 0};
      tbl_b[1] = '{395, 295, 1'b1, 151, 111};
      tbl_b[2] = '{396, 295, 1'b0, 0, 0};
      tbl_b[3] = '{244, 296, 1'b0, 0, 0};
      tbl_b[4] = '{244, 183, 1'b0, 0, 0};

      // reset state
      pixelX = 11'd300; pixelY = 11'd200;
      tick(); tick();
      reset = 1'b0;
      tick();
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_in", int'(InsideRectangle), 0);

      // partial visibility at topY=-40, then hold position probes
      start = 1'b1; tick(); start = 1'b0;
      chk("start_busy", int'(busy), 1);
      frames(9);
      foreach (tbl_a[i]) probe($sformatf("slide_in%0d", i), tbl_a[i]);
      frames(N_IN - 9);
      foreach (tbl_b[i]) probe($sformatf("hold%0d", i), tbl_b[i]);

      // hold frame 10: ignored start, then skip; count frames to done
      frames(10);
      start = 1'b1; tick(); start = 1'b0;
      skip = 1'b1; tick(); skip = 1'b0;
      exp_k = SKIP_EN ? 37 : (N_HOLD - 10) + 37;
      done_at = -1; done_cnt = 0; busy_ok = 1;
      for (k = 1; k <= 400 && done_at < 0; k++) begin
         startOfFrame = 1'b1; tick();
         if (done) begin done_at = k; done_cnt++; end
         else if (!busy) busy_ok = 0;
         startOfFrame = 1'b0; tick();
         if (done) done_cnt++;
      end
      chk("run_frames_to_done", done_at, exp_k);
      chk("run_busy_high", int'(busy_ok), 1);
      chk("done_width", done_cnt, 1);
      chk("idle_busy", int'(busy), 0);

      // reset mid-HOLD drops the run without done
      start = 1'b1; tick(); start = 1'b0;
      frames(40);
      chk("midhold_busy", int'(busy), 1);
      pixelX = 11'd300; pixelY = 11'd200;
      reset = 1'b1; tick(); tick(); reset = 1'b0;
      chk("rst2_busy", int'(busy), 0);
      chk("rst2_done", int'(done), 0);
      chk("rst2_in", int'(InsideRectangle), 0);
      done_cnt = 0;
      for (int i = 0; i < 200; i++) begin
         startOfFrame = (i % 2 == 0); tick();
         if (done || busy) done_cnt++;
      end
      startOfFrame = 1'b0;
      chk("rst2_no_done", done_cnt, 0);

      // random stimulus against the model
      reset = 1'b1; tick(); reset = 1'b0;
      m_act = 0; m_fin = 0; in_f = 0; out_f = -1; out_base = 0;
      for (int c = 0; c < 8000; c++) begin
         r   = ($urandom_range(0, 2999) == 0);
         st  = ($urandom_range(0, 49) == 0);
         sof = ($urandom_range(0, 2) == 0);
         sk  = ($urandom_range(0, 59) == 0);
         px  = $urandom_range(230, 410);
         py  = $urandom_range(0, 620);
         reset = r; start = st; startOfFrame = sof; skip = sk;
         pixelX = 11'(px); pixelY = 11'(py);
         top  = m_top();
         e_in = (m_act && px >= 244 && px < 396 && py >= top && py < top + 112) ? 1 : 0;
         e_ox = e_in ? ((px - 244) & 'h7FF) : 0;
         e_oy = e_in ? ((py - top) & 'h7FF) : 0;
         tick();
         m_step(r, st, sof, sk);
         if (r) begin e_in = 0; e_ox = 0; e_oy = 0; end
         chk("rnd_busy", int'(busy), int'(m_act));
         chk("rnd_done", int'(done), int'(m_fin));
         chk("rnd_in", int'(InsideRectangle), e_in);
         chk("rnd_ox", int'(offsetX), e_ox);
         chk("rnd_oy", int'(offsetY), e_oy);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/next_level_banner_ctrl.md
Name: next_level_banner_ctrl

Overview:
Position and animation controller that drives the "Next Level" transition bitmap's rectangle interface: InsideRectangle, offsetX and offsetY.
- On a start pulse, slides the 152x112 banner down from above the screen to a target position, holds it, slides it off the bottom, then pulses done.
- Sits between the VGA pixel-coordinate source and the banner bitmap; the game-state controller issues start and waits for done.

Parameters:
OBJECT_WIDTH, 152, banner width in pixels (38 bitmap columns x4 scale)
OBJECT_HEIGHT, 112, banner height in pixels (28 bitmap rows x4 scale)
TARGET_X, 244, fixed left edge, in pixels
TARGET_Y, 184, hold-position top edge, in pixels
SPEED_Y, 8, vertical move per frame, in pixels
HOLD_FRAMES, 120, number of frames the banner stays at TARGET_Y
SCREEN_H, 480, visible screen height; slide-out ends when the top edge reaches this

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request to run the animation
startOfFrame  in  1  single-cycle pulse, once per frame
pixelX  in  11  current pixel column
pixelY  in  11  current pixel row
skip  in  1  abort request (active only with BANNER_SKIP_EN)
InsideRectangle  out  1  current pixel lies within the banner
offsetX  out  11  pixelX - TARGET_X when inside, else 0
offsetY  out  11  pixelY - topY when inside, else 0
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the animation completes

Behaviour:
- Internal topY: 12-bit signed. Its value in IDLE and after reset is -OBJECT_HEIGHT (-112).
- Reset (synchronous, any state):
  - state goes to IDLE; topY = -112; holdCnt = 0.
  - InsideRectangle, offsetX, offsetY, busy and done are all 0 on the next edge.
  - Reset mid-animation drops the animation; done is not pulsed.
- State machine: IDLE -> SLIDE_IN -> HOLD -> SLIDE_OUT -> FINISH -> IDLE.
  - IDLE: start=1 moves to SLIDE_IN. If startOfFrame is high in the same cycle, it does not move the banner.
  - SLIDE_IN: on each startOfFrame, topY += SPEED_Y. If topY + SPEED_Y >= TARGET_Y, set topY = TARGET_Y (clamp), clear holdCnt and move to HOLD.
  - HOLD: on each startOfFrame, holdCnt++. On the startOfFrame where holdCnt == HOLD_FRAMES-1, move to SLIDE_OUT.
  - SLIDE_OUT: on each startOfFrame, topY += SPEED_Y. When the new topY >= SCREEN_H, move to FINISH.
  - FINISH: done=1 for exactly one cycle; next cycle go to IDLE with topY = -112.
  - start is ignored in every state except IDLE; it is not queued.
- Position only changes on startOfFrame, so the banner never moves mid-frame.
- Hit test (registered, 1-cycle latency from pixelX/pixelY):
  - Inside when state is not IDLE, TARGET_X <= pixelX < TARGET_X+OBJECT_WIDTH, and topY <= pixelY < topY+OBJECT_HEIGHT.
  - The Y comparison is 12-bit signed; pixelY is zero-extended.
  - Partial visibility is handled: at topY = -40, pixelY = 0 gives offsetY = 40.
  - offsetX and offsetY are the 11-bit truncated differences when inside; both are 0 when outside.
  - Downstream, the bitmap adds one more cycle of latency; the pixel pipeline compensates.
- busy is registered and follows state (busy=0 in IDLE, 1 otherwise, including FINISH).

Optional Feature:
BANNER_SKIP_EN
- Defined: skip=1 in SLIDE_IN or HOLD moves the FSM to SLIDE_OUT on the next edge; topY is unchanged and holdCnt is cleared. skip in IDLE, SLIDE_OUT or FINISH is ignored. If skip and startOfFrame coincide, the transition happens and no move is applied that cycle.
- Undefined: the skip port exists but is ignored; no skip logic is synthesised.

Test Plan:
1. Assert reset for 2 cycles mid-HOLD -> state IDLE, topY=-112, busy=0, done=0, InsideRectangle=0; no done pulse afterwards.
2. Pulse start, then give 37 startOfFrame pulses -> state HOLD after the 37th, topY=184. Drive pixel (244,184) -> next cycle InsideRectangle=1, offsetX=0, offsetY=0.
3. In HOLD, drive pixel (395,295) -> InsideRectangle=1, offsets (151,111). Drive pixel (396,295) and then (244,296) -> InsideRectangle=0, offsets 0.
4. Full run with defaults -> done pulses exactly once, 1 cycle wide, after 37+120+37 startOfFrame pulses; busy is high throughout; a second start during HOLD has no effect.
5. After 9 frames in SLIDE_IN (topY=-40), drive pixel (300,0) -> InsideRectangle=1, offsetX=56, offsetY=40. Drive pixel (300,72) -> InsideRectangle=0.
6. With BANNER_SKIP_EN defined, assert skip at HOLD frame 10 -> SLIDE_OUT from topY=184, done after 37 more frames. With the macro undefined, the same stimulus gives the full 120-frame hold.
